reg_access_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port 8×8 register array inside `tt_um_register`. It shares the array between the pin-side host interface (requester 0) and the internal shift/scan engine (requester 1). It serialises their read/write commands into array cycles, returns read data with a fixed latency and alternates fairly under contention. An optional lock gives one requester back-to-back ownership.

---
 rtl/reg_access_arbiter_if.sv | 30 +++
 rtl/reg_access_arbiter.sv | 109 ++++++++++
 tb/tb_reg_access_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/reg_access_arbiter_if.sv
// Requester and register-array signal bundle for reg_access_arbiter.
// slave: the arbiter side. master: requesters plus the array model.
interface reg_access_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              req0,   req1;
  logic              we0,    we1;
  logic              lock0,  lock1;
  logic [ADDR_W-1:0] addr0,  addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0,   gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              rf_en;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, rf_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, rf_en, rf_we, rf_addr, rf_wdata
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, rf_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, rf_en, rf_we, rf_addr, rf_wdata
  );
endinterface

// File: rtl/reg_access_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port register array.
// One command per IDLE->ISSUE(->RESP) pass; optional lock keeps ownership.
module reg_access_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  ena,
  reg_access_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q;
  logic              last_q;      // requester granted most recently
  logic              lock_q;      // ownership retained
  logic              lock_own_q;  // which requester holds the lock
  logic              own_q;       // owner of the command in flight
  logic              lkc_q;       // lock request latched with the command
  logic              gnt0_q, gnt1_q, rv0_q, rv1_q;
  logic              rf_en_q, rf_we_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_wdata_q, rdata_q;

  logic own_req, own_lk, lock_eff, elig0, elig1, any_elig, win;

  // Lock stays effective only while its owner keeps both req and lock high;
  // otherwise both requesters compete in the same cycle.
  always_comb begin
    own_req  = lock_own_q ? bus.req1  : bus.req0;
    own_lk   = lock_own_q ? bus.lock1 : bus.lock0;
    lock_eff = lock_q & own_req & own_lk;
    elig0    = bus.req0 & (~lock_eff | ~lock_own_q);
    elig1    = bus.req1 & (~lock_eff |  lock_own_q);
    any_elig = elig0 | elig1;
    win      = (elig0 & elig1) ? ~last_q : elig1;
  end

  // Sequencer FSM with registered handshake and array outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_q     <= 1'b0;
      lock_own_q <= 1'b0;
      own_q      <= 1'b0;
      lkc_q      <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      rf_en_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      rdata_q    <= '0;
    end else begin
      // Pulses and array strobes last one cycle unless re-armed below.
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      rf_en_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (!lock_eff) lock_q <= 1'b0;
          if (ena && any_elig) begin
            own_q      <= win;
            lkc_q      <= win ? bus.lock1 : bus.lock0;
            rf_en_q    <= 1'b1;
            rf_we_q    <= win ? bus.we1 : bus.we0;
            rf_addr_q  <= win ? bus.addr1 : bus.addr0;
            rf_wdata_q <= win ? bus.wdata1 : bus.wdata0;
            gnt0_q     <= ~win;
            gnt1_q     <= win;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          last_q     <= own_q;
          lock_q     <= lkc_q;
          lock_own_q <= own_q;
          state_q    <= rf_we_q ? IDLE : RESP;
        end
        RESP: begin
          // Array read data is valid the cycle after the strobe.
          rdata_q <= bus.rf_rdata;
          rv0_q   <= ~own_q;
          rv1_q   <= own_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.rvalid0  = rv0_q;
  assign bus.rvalid1  = rv1_q;
  assign bus.rdata    = rdata_q;
  assign bus.rf_en    = rf_en_q;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_addr  = rf_addr_q;
  assign bus.rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_reg_access_arbiter.sv
// Randomized plus directed bench for reg_access_arbiter against a
// transaction-timed reference model (edge numbers, not FSM states).
module tb_reg_access_arbiter;
  logic gclk = 1'b0;
  logic rst, ena;

  reg_access_arbiter_if #(.ADDR_W(3), .DATA_W(8)) bus ();

  reg_access_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk (gclk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  always #5 gclk = ~gclk;

  // Register array: synchronous read/write, contents preset on reset.
  logic [7:0] arr [8];
  always @(posedge gclk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) arr[i] <= 8'(i * 37 + 5);
    end else if (bus.rf_en) begin
      if (bus.rf_we) arr[bus.rf_addr] <= bus.rf_wdata;
      bus.rf_rdata <= arr[bus.rf_addr];
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the arbiter is free at edge free_at; a grant at edge e
  // shows during cycle e, a write frees it at e+2, a read at e+3 with its
  // rvalid shown after edge e+2.
  int         ed = 0, free_at = 0, rv_due = -1;
  bit         rv_id, m_last, m_lock, m_owner;
  logic [7:0] rv_data, m_rdata;
  logic [7:0] mmem [8];
  logic [1:0] e_gnt, e_rv;
  logic [12:0] e_rf;

  task automatic model_edge();
    bit [1:0] r, lk, el;
    bit       w, we;
    bit [2:0] a;
    bit [7:0] d;
    e_gnt = '0; e_rv = '0; e_rf = '0;
    if (rst) begin
      free_at = ed + 1; rv_due = -1; m_last = 1'b1; m_lock = 1'b0; m_rdata = '0;
      for (int i = 0; i < 8; i++) mmem[i] = 8'(i * 37 + 5);
      return;
    end
    if (rv_due == ed) begin
      e_rv[rv_id] = 1'b1; m_rdata = rv_data; rv_due = -1;
    end
    if (ed >= free_at) begin
      r  = {bus.req1, bus.req0};
      lk = {bus.lock1, bus.lock0};
      if (m_lock && !(r[m_owner] && lk[m_owner])) m_lock = 1'b0;
      el = m_lock ? (2'b01 << m_owner) : r;
      if (ena && el != 2'b00) begin
        w  = (el == 2'b11) ? !m_last : el[1];
        we = w ? bus.we1 : bus.we0;
        a  = w ? bus.addr1 : bus.addr0;
        d  = w ? bus.wdata1 : bus.wdata0;
        e_gnt[w] = 1'b1;
        e_rf = {1'b1, we, a, d};
        if (we) begin
          mmem[a] = d; free_at = ed + 2;
        end else begin
          rv_due = ed + 2; rv_id = w; rv_data = mmem[a]; free_at = ed + 3;
        end
        m_last = w; m_lock = w ? bus.lock1 : bus.lock0; m_owner = w;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge gclk); #1;
    chk("gnt",    {30'd0, bus.gnt1, bus.gnt0}, {30'd0, e_gnt});
    chk("rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, {30'd0, e_rv});
    chk("rf",     {19'd0, bus.rf_en, bus.rf_we, bus.rf_addr, bus.rf_wdata}, {19'd0, e_rf});
    chk("rdata",  {24'd0, bus.rdata}, {24'd0, m_rdata});
    ed++;
    @(negedge gclk);
  endtask

  task automatic set_cmd(input bit i, input bit rq, input bit we, input bit [2:0] a,
                         input bit [7:0] d, input bit lk);
    if (i) begin
      bus.req1 = rq; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = lk;
    end else begin
      bus.req0 = rq; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = lk;
    end
  endtask

  // Present a command and step until its grant appears; req stays high.
  task automatic req_until_gnt(input bit i, input bit we, input bit [2:0] a,
                               input bit [7:0] d, input bit lk);
    bit seen = 1'b0;
    set_cmd(i, 1'b1, we, a, d, lk);
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = i ? bus.gnt1 : bus.gnt0;
    end
    chk("gnt_wait", {31'd0, seen}, 32'd1);
  endtask

  bit hold0, hold1;

  initial begin
    rst = 1'b1; ena = 1'b1;
    set_cmd(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    set_cmd(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    @(negedge gclk);
    step(); step();
    rst = 1'b0;
    step();

    // Single write then read-back by the other requester.
    req_until_gnt(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0);
    bus.req0 = 1'b0;
    step();
    req_until_gnt(1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    bus.req1 = 1'b0;
    step(); step(); step();
    chk("readback", {24'd0, bus.rdata}, 32'h0000_00A5);

    // Contention: both held with writes.
    set_cmd(1'b0, 1'b1, 1'b1, 3'd1, 8'h11, 1'b0);
    set_cmd(1'b1, 1'b1, 1'b1, 3'd2, 8'h22, 1'b0);
    for (int k = 0; k < 24; k++) begin
      step();
      if (bus.gnt0) bus.wdata0 = bus.wdata0 + 8'd1;
      if (bus.gnt1) bus.wdata1 = bus.wdata1 + 8'd1;
    end

    // Lock: requester 0 locked for three commands while requester 1 waits.
    for (int k = 0; k < 3; k++) req_until_gnt(1'b0, 1'b1, 3'(4 + k), 8'(8'h40 + k), 1'b1);
    req_until_gnt(1'b0, 1'b0, 3'd5, 8'h00, 1'b0);
    bus.req0 = 1'b0;
    for (int k = 0; k < 6; k++) step();
    bus.req1 = 1'b0;
    step(); step();

    // Enable gating after a fresh reset.
    rst = 1'b1; step(); rst = 1'b0;
    ena = 1'b0;
    set_cmd(1'b0, 1'b1, 1'b0, 3'd6, 8'h00, 1'b0);
    set_cmd(1'b1, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) step();
    ena = 1'b1;
    req_until_gnt(1'b0, 1'b0, 3'd6, 8'h00, 1'b0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // Reset during RESP of a read, then a normal read.
    req_until_gnt(1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    bus.req1 = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    req_until_gnt(1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    bus.req1 = 1'b0;
    step(); step(); step();

    // Randomized traffic with occasional enable drops and resets.
    hold0 = 1'b0; hold1 = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      ena = ($urandom_range(0, 9) != 0);
      if (!hold0) begin
        set_cmd(1'b0, $urandom_range(0, 9) < 7, 1'($urandom), 3'($urandom), 8'($urandom),
                $urandom_range(0, 9) < 4);
        hold0 = bus.req0;
      end
      if (!hold1) begin
        set_cmd(1'b1, $urandom_range(0, 9) < 7, 1'($urandom), 3'($urandom), 8'($urandom),
                $urandom_range(0, 9) < 4);
        hold1 = bus.req1;
      end
      step();
      if (bus.gnt0) hold0 = 1'b0;
      if (bus.gnt1) hold1 = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
